// File: rtl/tx_bus_control.sv
// Transmit-side frame builder: header, upload-RAM payload or status byte, then link start/wait.
// Define TX_BUS_TIMEOUT_EN to add a tx_done watchdog in WAIT.
module tx_bus_control #(
    parameter logic [7:0]  MASTER_DA   = 8'h00,
    parameter int unsigned PAYLOAD_LEN = 128,
    parameter int unsigned TIMEOUT_CYC = 4096
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ini_done,
    input  logic [2:0]  rack_id,
    input  logic [3:0]  slot_id,
    input  logic        rx_flag,
    input  logic [7:0]  rx_mode,
    input  logic [23:0] rx_addr,
    output logic        lurb_rden,
    output logic [23:0] lurb_raddr,
    input  logic [7:0]  lurb_rdata,
    output logic        tx_buf_wren,
    output logic [10:0] tx_buf_waddr,
    output logic [7:0]  tx_buf_wdata,
    output logic [10:0] tx_len,
    output logic        tx_start,
    input  logic        tx_done,
    output logic        tx_busy,
    output logic        tx_overrun,
    output logic        tx_timeout
);

    localparam int unsigned AW = 24;
    localparam int unsigned BW = 11;
    localparam int unsigned CW = 11;
    localparam logic [BW-1:0] LEN_PAY = BW'(7 + PAYLOAD_LEN);
    localparam logic [BW-1:0] LEN_STA = BW'(8);
    localparam logic [CW-1:0] N_LAST  = CW'(PAYLOAD_LEN - 1);
    localparam logic [CW-1:0] N_END   = CW'(PAYLOAD_LEN);
    localparam logic [7:0]    MODE_DL = 8'd2;

    if (PAYLOAD_LEN < 1 || PAYLOAD_LEN > 1024 || TIMEOUT_CYC < 1) begin : g_cfg_err
        $error("tx_bus_control: parameter out of range");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR,
        S_PAYLOAD,
        S_STATUS,
        S_START,
        S_WAIT
    } state_t;

    state_t          state, state_n;
    logic [7:0]      mode_q, mode_n;
    logic [7:0]      sa_q, sa_n;
    logic [AW-1:0]   addr_q, addr_n;
    logic [CW-1:0]   cnt_q, cnt_n;
    logic            rden_q, rden_n;
    logic [AW-1:0]   raddr_q, raddr_n;
    logic            wren_q, wren_n;
    logic [BW-1:0]   waddr_q, waddr_n;
    logic [7:0]      wdata_q, wdata_n;
    logic            pay_sel_q, pay_sel_n;
    logic [BW-1:0]   len_q, len_n;
    logic            start_q, start_n;
    logic            busy_q, busy_n;
    logic            overrun_q, overrun_n;
    logic            tmo_hit;
    logic [7:0]      sa_c;
    logic [7:0]      hdr_byte_c;

    // Source address of this card, 8-bit modulo arithmetic
    assign sa_c = 8'(8'(rack_id) * 8'd14) + 8'd14 - 8'(slot_id);

    // Header byte for position cnt_q (1..6); byte 0 is written at capture
    always_comb begin
        hdr_byte_c = MASTER_DA;
        case (cnt_q[2:0])
            3'd1:    hdr_byte_c = sa_q;
            3'd2:    hdr_byte_c = 8'h60;
            3'd3:    hdr_byte_c = mode_q;
            3'd4:    hdr_byte_c = addr_q[23:16];
            3'd5:    hdr_byte_c = addr_q[15:8];
            3'd6:    hdr_byte_c = addr_q[7:0];
            default: hdr_byte_c = MASTER_DA;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next state plus next values of every registered output and counter
    always_comb begin
        state_n   = state;
        mode_n    = mode_q;
        sa_n      = sa_q;
        addr_n    = addr_q;
        cnt_n     = cnt_q;
        raddr_n   = raddr_q;
        waddr_n   = waddr_q;
        wdata_n   = wdata_q;
        len_n     = len_q;
        busy_n    = busy_q;
        rden_n    = 1'b0;
        wren_n    = 1'b0;
        pay_sel_n = 1'b0;
        start_n   = 1'b0;
        overrun_n = busy_q & rx_flag;

        case (state)
            S_IDLE: begin
                if (rx_flag && ini_done && (rx_mode <= MODE_DL)) begin
                    state_n = S_HDR;
                    mode_n  = rx_mode;
                    addr_n  = rx_addr;
                    sa_n    = sa_c;
                    busy_n  = 1'b1;
                    cnt_n   = CW'(1);
                    wren_n  = 1'b1;
                    waddr_n = '0;
                    wdata_n = MASTER_DA;
                    len_n   = (rx_mode == MODE_DL) ? LEN_STA : LEN_PAY;
                end
            end
            S_HDR: begin
                cnt_n = cnt_q + CW'(1);
                if (cnt_q == CW'(7)) begin
                    cnt_n = '0;
                    if (mode_q == MODE_DL) begin
                        wren_n  = 1'b1;
                        waddr_n = BW'(7);
                        wdata_n = 8'hAA;
                        state_n = S_STATUS;
                    end else begin
                        rden_n  = 1'b1;
                        raddr_n = addr_q;
                        state_n = S_PAYLOAD;
                    end
                end else begin
                    wren_n  = 1'b1;
                    waddr_n = cnt_q;
                    wdata_n = hdr_byte_c;
                end
            end
            S_PAYLOAD: begin
                // cnt_q = index of the read whose data arrives next cycle
                if (cnt_q == N_END) begin
                    start_n = 1'b1;
                    cnt_n   = '0;
                    state_n = S_START;
                end else begin
                    wren_n    = 1'b1;
                    pay_sel_n = 1'b1;
                    waddr_n   = cnt_q + BW'(7);
                    cnt_n     = cnt_q + CW'(1);
                    if (cnt_q != N_LAST) begin
                        rden_n  = 1'b1;
                        raddr_n = raddr_q + AW'(1);
                    end
                end
            end
            S_STATUS: begin
                start_n = 1'b1;
                state_n = S_START;
            end
            S_START: begin
                state_n = S_WAIT;
            end
            S_WAIT: begin
                if (tx_done || tmo_hit) begin
                    busy_n  = 1'b0;
                    state_n = S_IDLE;
                end
            end
            default: begin
                state_n = S_IDLE;
                busy_n  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mode_q    <= '0;
            sa_q      <= '0;
            addr_q    <= '0;
            cnt_q     <= '0;
            rden_q    <= 1'b0;
            raddr_q   <= '0;
            wren_q    <= 1'b0;
            waddr_q   <= '0;
            wdata_q   <= '0;
            pay_sel_q <= 1'b0;
            len_q     <= '0;
            start_q   <= 1'b0;
            busy_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            mode_q    <= mode_n;
            sa_q      <= sa_n;
            addr_q    <= addr_n;
            cnt_q     <= cnt_n;
            rden_q    <= rden_n;
            raddr_q   <= raddr_n;
            wren_q    <= wren_n;
            waddr_q   <= waddr_n;
            wdata_q   <= wdata_n;
            pay_sel_q <= pay_sel_n;
            len_q     <= len_n;
            start_q   <= start_n;
            busy_q    <= busy_n;
            overrun_q <= overrun_n;
        end
    end

`ifdef TX_BUS_TIMEOUT_EN
    localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);
    logic [TW-1:0] tmr_q;
    logic          tmo_q;

    // Watchdog counts WAIT cycles; it sits at zero outside WAIT
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tmr_q <= '0;
            tmo_q <= 1'b0;
        end else begin
            tmr_q <= (state == S_WAIT) ? tmr_q + TW'(1) : '0;
            tmo_q <= (state == S_WAIT) && !tx_done && tmo_hit;
        end
    end

    assign tmo_hit    = (tmr_q == TW'(TIMEOUT_CYC - 1));
    assign tx_timeout = tmo_q;
`else
    assign tmo_hit    = 1'b0;
    assign tx_timeout = 1'b0;
`endif

    // RAM data lands one cycle after its read, so payload bytes bypass the data flop
    assign tx_buf_wdata = pay_sel_q ? lurb_rdata : wdata_q;
    assign lurb_rden    = rden_q;
    assign lurb_raddr   = raddr_q;
    assign tx_buf_wren  = wren_q;
    assign tx_buf_waddr = waddr_q;
    assign tx_len       = len_q;
    assign tx_start     = start_q;
    assign tx_busy      = busy_q;
    assign tx_overrun   = overrun_q;

endmodule
